// File: rtl/sha256_pkg.sv
// Shared SHA-256 schedule definitions: round constants, word sizing, sigma helpers, streamer state.
// Pure declarations, no latency; no handshake.
// Imported by the window stages and the schedule streamer alike.
package sha256_pkg;

    localparam int WORD_W = 32;
    localparam int ROUNDS = 64;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    localparam logic [31:0] SHA256_K [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    function automatic logic [WORD_W-1:0] sigma0_256(input logic [WORD_W-1:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
    endfunction

    function automatic logic [WORD_W-1:0] sigma1_256(input logic [WORD_W-1:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
    endfunction

endpackage

// File: rtl/sha256_w_next.sv
// Next schedule word from a 16-word window: W[t+16] = s1(W[t+14]) + W[t+9] + s0(W[t+1]) + W[t].
// Latency: purely combinational.
// Backpressure: none; the caller decides when to commit the result.
module sha256_w_next
    import sha256_pkg::*;
(
    input  logic [WORD_W-1:0] w_0,
    input  logic [WORD_W-1:0] w_1,
    input  logic [WORD_W-1:0] w_9,
    input  logic [WORD_W-1:0] w_14,
    output logic [WORD_W-1:0] w_15
);

    assign w_15 = sigma1_256(w_14) + w_9 + sigma0_256(w_1) + w_0;

endmodule

// File: rtl/sha256_w_stream.sv
// Expands one 512-bit block into W[0..63], one word per beat; with SHA256_W_ADD_K_EN defined emits W[t]+K[t].
// Latency: first word 1 cycle after block accept; 64 cycles/block at full rate, back-to-back without bubble.
// Backpressure: w_ready low freezes all state; blk_ready only in IDLE or on the accepted final beat.
module sha256_w_stream
    import sha256_pkg::*;
(
    input  logic              CLK,
    input  logic              RST,
    input  logic              blk_valid,
    output logic              blk_ready,
    input  logic [511:0]      block_in,
    output logic              w_valid,
    input  logic              w_ready,
    output logic [WORD_W-1:0] w_data,
    output logic [5:0]        w_idx,
    output logic              w_last
);

    state_e            state;
    logic [WORD_W-1:0] win [0:15];
    logic [5:0]        t;
    logic [WORD_W-1:0] w_new;
    logic [WORD_W-1:0] nxt_word;
    logic [WORD_W-1:0] nxt_data;
    logic              accept;
    logic              last_beat;
    logic              load;

    sha256_w_next u_w_next (
        .w_0  (win[0]),
        .w_1  (win[1]),
        .w_9  (win[9]),
        .w_14 (win[14]),
        .w_15 (w_new)
    );

    assign accept    = w_valid && w_ready;
    assign last_beat = (t == 6'(ROUNDS - 1));
    assign blk_ready = (state == IDLE) || ((state == RUN) && last_beat && w_ready);
    assign load      = blk_valid && blk_ready;
    assign w_idx     = t;

    // The output register is loaded with the word that win[0] will hold next cycle.
    assign nxt_word = load ? block_in[511 -: WORD_W] : win[1];

`ifdef SHA256_W_ADD_K_EN
    logic [5:0] nxt_idx;
    assign nxt_idx  = load ? 6'd0 : t + 6'd1;
    assign nxt_data = nxt_word + SHA256_K[nxt_idx];
`else
    assign nxt_data = nxt_word;
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            state   <= IDLE;
            t       <= '0;
            w_valid <= 1'b0;
            w_data  <= '0;
            w_last  <= 1'b0;
            for (int i = 0; i < 16; i++) begin
                win[i] <= '0;
            end
        end else if (load) begin
            for (int i = 0; i < 16; i++) begin
                win[i] <= block_in[511 - WORD_W*i -: WORD_W];
            end
            state   <= RUN;
            t       <= '0;
            w_valid <= 1'b1;
            w_data  <= nxt_data;
            w_last  <= 1'b0;
        end else if (accept) begin
            if (last_beat) begin
                state   <= IDLE;
                t       <= '0;
                w_valid <= 1'b0;
                w_last  <= 1'b0;
            end else begin
                for (int i = 0; i < 15; i++) begin
                    win[i] <= win[i+1];
                end
                win[15] <= w_new;
                t       <= t + 6'd1;
                w_data  <= nxt_data;
                w_last  <= (t == 6'(ROUNDS - 2));
            end
        end
    end

endmodule

// File: tb/tb_sha256_w_stream.sv
// Directed bench for sha256_w_stream: "abc" block, stalls, back-to-back blocks, mid-block reset, idle.
module tb_sha256_w_stream;

    logic         CLK;
    logic         RST;
    logic         blk_valid;
    logic         blk_ready;
    logic [511:0] block_in;
    logic         w_valid;
    logic         w_ready;
    logic [31:0]  w_data;
    logic [5:0]   w_idx;
    logic         w_last;

    int n_chk  = 0;
    int n_pass = 0;

    logic [511:0] blocks [0:1];
    logic [31:0]  w_exp  [0:1][0:63];
    logic [15:0]  lfsr = 16'hACE1;

    sha256_w_stream dut (
        .CLK       (CLK),
        .RST       (RST),
        .blk_valid (blk_valid),
        .blk_ready (blk_ready),
        .block_in  (block_in),
        .w_valid   (w_valid),
        .w_ready   (w_ready),
        .w_data    (w_data),
        .w_idx     (w_idx),
        .w_last    (w_last)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp)
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        else
            n_pass++;
    endtask

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] ref_s0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] ref_s1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    task automatic fill_exp(input int b);
        for (int k = 0; k < 16; k++)
            w_exp[b][k] = blocks[b][511 - 32*k -: 32];
        for (int k = 16; k < 64; k++)
            w_exp[b][k] = ref_s1(w_exp[b][k-2]) + w_exp[b][k-7]
                        + ref_s0(w_exp[b][k-15]) + w_exp[b][k-16];
    endtask

    function automatic logic [31:0] exp_word(input int b, input int k);
`ifdef SHA256_W_ADD_K_EN
        return w_exp[b][k] + sha256_pkg::SHA256_K[k];
`else
        return w_exp[b][k];
`endif
    endfunction

    // Feeds nblk blocks starting at blocks[first] and drains every beat.
    task automatic run(input int first, input int nblk, input bit rnd, input bit spot);
        int          beats;
        int          cyc;
        int          b;
        int          k;
        int          total;
        bit          held;
        bit          rdy;
        logic [31:0] h_data;
        logic [5:0]  h_idx;
        logic        h_last;
        total = 64 * nblk;
        beats = 0;
        cyc   = 0;
        held  = 1'b0;
        h_data = '0;
        h_idx  = '0;
        h_last = 1'b0;
        blk_valid = 1'b1;
        block_in  = blocks[first];
        w_ready   = 1'b1;
        #1;
        check("blk_ready_idle", 32'(blk_ready), 32'd1);
        @(negedge CLK);
        if (nblk > 1) block_in = blocks[first + 1];
        else          blk_valid = 1'b0;
        while (beats < total && cyc < 2000) begin
            b = first + beats / 64;
            k = beats % 64;
            if (beats >= 64) blk_valid = 1'b0;
            check("w_valid_run", 32'(w_valid), 32'd1);
            if (held) begin
                check("stall_data", w_data, h_data);
                check("stall_idx", 32'(w_idx), 32'(h_idx));
                check("stall_last", 32'(w_last), 32'(h_last));
            end
            if (rnd) begin
                lfsr = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
                rdy  = lfsr[0];
            end else begin
                rdy = 1'b1;
            end
            w_ready = rdy;
            #1;
            check("blk_ready_run", 32'(blk_ready), 32'((k == 63) && rdy));
            if (rdy) begin
                check("w_data", w_data, exp_word(b, k));
                check("w_idx", 32'(w_idx), 32'(k));
                check("w_last", 32'(w_last), 32'(k == 63));
                if (spot && b == first) begin
`ifdef SHA256_W_ADD_K_EN
                    if (k == 0)  check("W0_plus_K0", w_data, 32'hA3EC9318);
`else
                    if (k == 0)  check("W0", w_data, 32'h61626380);
                    if (k == 15) check("W15", w_data, 32'h00000018);
                    if (k == 16) check("W16", w_data, 32'h61626380);
                    if (k == 17) check("W17", w_data, 32'h000F0000);
                    if (k == 63) check("W63", w_data, 32'h12B1EDEB);
`endif
                end
                held = 1'b0;
                beats++;
            end else begin
                held   = 1'b1;
                h_data = w_data;
                h_idx  = w_idx;
                h_last = w_last;
            end
            @(negedge CLK);
            cyc++;
        end
        check("beat_count", 32'(beats), 32'(total));
        if (!rnd) check("no_gap_cycles", 32'(cyc), 32'(total));
        check("idle_w_valid", 32'(w_valid), 32'd0);
        check("idle_blk_ready", 32'(blk_ready), 32'd1);
    endtask

    initial begin
        int n;
        blocks[0] = {32'h61626380, {14{32'h00000000}}, 32'h00000018};
        blocks[1] = {32'h80000000, {15{32'h00000000}}};
        fill_exp(0);
        fill_exp(1);

        RST       = 1'b1;
        blk_valid = 1'b0;
        w_ready   = 1'b0;
        block_in  = '0;
        repeat (3) @(negedge CLK);
        check("rst_w_valid", 32'(w_valid), 32'd0);
        check("rst_blk_ready", 32'(blk_ready), 32'd1);
        check("rst_w_idx", 32'(w_idx), 32'd0);
        check("rst_w_data", w_data, 32'd0);
        check("rst_w_last", 32'(w_last), 32'd0);
        RST = 1'b0;

        repeat (10) begin
            @(negedge CLK);
            check("idle_hold_valid", 32'(w_valid), 32'd0);
            check("idle_hold_ready", 32'(blk_ready), 32'd1);
        end

        run(0, 1, 1'b0, 1'b1);
        run(0, 1, 1'b1, 1'b0);
        run(0, 2, 1'b0, 1'b0);

        blk_valid = 1'b1;
        block_in  = blocks[0];
        w_ready   = 1'b1;
        @(negedge CLK);
        blk_valid = 1'b0;
        n = 0;
        while (w_idx != 6'd20 && n < 100) begin
            @(negedge CLK);
            n++;
        end
        check("reach_t20", 32'(w_idx), 32'd20);
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        check("mid_rst_w_valid", 32'(w_valid), 32'd0);
        check("mid_rst_blk_ready", 32'(blk_ready), 32'd1);
        check("mid_rst_w_idx", 32'(w_idx), 32'd0);
        @(negedge CLK);
        check("post_rst_w_valid", 32'(w_valid), 32'd0);

        run(0, 1, 1'b0, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
